// File: rtl/sc_pkg.sv
// sc_pkg: shared types, mode encodings and LFSR tap table for the stochastic stream engine.
package sc_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sc_state_t;

    localparam logic [1:0] SC_AND  = 2'd0;
    localparam logic [1:0] SC_NAND = 2'd1;
    localparam logic [1:0] SC_OR   = 2'd2;
    localparam logic [1:0] SC_XOR  = 2'd3;

    // Bit t set means cur[t] feeds the new MSB; mask is the feedback polynomial minus x^width.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            4:       return 16'h0003;
            5:       return 16'h0005;
            6:       return 16'h0003;
            7:       return 16'h0003;
            8:       return 16'h00A9;
            9:       return 16'h0011;
            10:      return 16'h0009;
            11:      return 16'h0005;
            12:      return 16'h0053;
            13:      return 16'h001B;
            14:      return 16'h002B;
            15:      return 16'h0003;
            16:      return 16'hA011;
            default: return 16'h0003;
        endcase
    endfunction
endpackage

// File: rtl/sc_lfsr.sv
// sc_lfsr: maximal-length Fibonacci LFSR shifting right, with synchronous seed load.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] state
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= '0;
        else if (load)
            state <= WIDTH'(SEED);
        else if (en)
            state <= {^(state & TAPS), state[WIDTH-1:1]};
endmodule

// File: rtl/sc_stream_engine.sv
// sc_stream_engine: shared-LFSR stochastic number generators, bitwise combiner and
// full-period ones counter returning its result over a valid/ready handshake.
module sc_stream_engine
    import sc_pkg::*;
#(
    parameter int                  WIDTH    = 8,
    parameter int                  CHANNELS = 2,
    parameter int                  SEED     = 1,
    parameter int                  ROT_STEP = 1,
    parameter logic [CHANNELS-1:0] ISO_MASK = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CHANNELS*WIDTH-1:0] bin_in,
    input  logic [1:0]                mode,
    output logic                      busy,
    output logic [CHANNELS-1:0]       sn_out,
    output logic                      f_out,
    output logic [WIDTH-1:0]          result,
    output logic                      result_valid,
    input  logic                      result_ready
);
    localparam logic [WIDTH-1:0] LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    sc_state_t                 state;
    logic [WIDTH-1:0]          lfsr, cnt, acc, acc_nxt;
    logic [CHANNELS*WIDTH-1:0] bin_q;
    logic [1:0]                mode_q;
    logic [CHANNELS-1:0]       raw, sn, iso_q;
    logic [2*WIDTH-1:0]        dbl;
    logic                      f, run;

    assign run = state == RUN;
    assign dbl = {lfsr, lfsr};

    sc_lfsr #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state == IDLE && start),
        .en    (run),
        .state (lfsr)
    );

    // A window of the doubled state gives the left rotation without a zero-width slice.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        localparam int R = (k * ROT_STEP) % WIDTH;
        assign raw[k] = dbl[WIDTH-R +: WIDTH] < bin_q[k*WIDTH +: WIDTH];
        assign sn[k]  = ISO_MASK[k] ? iso_q[k] : raw[k];
    end

    always_comb begin
        f = mode_q == SC_AND ? &sn : mode_q == SC_NAND ? ~&sn : mode_q == SC_OR ? |sn : ^sn;
        acc_nxt = acc + WIDTH'(f);
    end

    assign sn_out       = run ? sn : '0;
    assign f_out        = run & f;
    assign busy         = state != IDLE;
    assign result_valid = state == DONE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            bin_q  <= '0;
            mode_q <= SC_AND;
            iso_q  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    bin_q  <= bin_in;
                    mode_q <= mode;
                    cnt    <= '0;
                    acc    <= '0;
                    iso_q  <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    iso_q <= raw;
                    acc   <= acc_nxt;
                    cnt   <= cnt + WIDTH'(1);
                    if (cnt == LAST) begin
                        result <= acc_nxt;
                        state  <= DONE;
                    end
                end
                DONE: if (result_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
endmodule
